// File: rtl/fetch_buffer_if.sv
// Handshake bundle between the fetch stage, the fetch buffer and decode.
// The buffer takes the slave view; whoever drives fetch/decode takes the master view.
interface fetch_buffer_if #(
  parameter int AW = 2
);
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_pc;
  logic [31:0]   in_instr;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic          out_misalign;
  logic [AW:0]   count;

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_misalign, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_misalign, count
  );
endinterface

// File: rtl/fetch_buffer.sv
// Small in-order instruction fetch queue between PC/imem and decode.
// Holds {pc, instr, misalign} entries; flush squashes everything on a redirect.
module fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic           clk,
  input logic           rst,
  fetch_buffer_if.slave fb
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [DEPTH-1:0] mis_mem;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          has_data;
  logic          push;
  logic          pop;

  // in_ready looks only at stored state, so a full buffer refuses a push even if decode pops
  assign has_data     = (cnt != '0);
  assign fb.in_ready  = (cnt != FULL);
  assign fb.out_valid = has_data && !fb.flush;
  assign push         = fb.in_valid && fb.in_ready && !fb.flush;
  assign pop          = fb.out_valid && fb.out_ready;

  always_ff @(posedge clk) begin
    if (rst || fb.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: the outputs are masked whenever the buffer is empty
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= fb.in_pc;
      instr_mem[wr_ptr] <= fb.in_instr;
      mis_mem[wr_ptr]   <= (fb.in_pc[1:0] != 2'b00);
    end
  end

  assign fb.out_pc       = has_data ? pc_mem[rd_ptr]    : '0;
  assign fb.out_instr    = has_data ? instr_mem[rd_ptr] : '0;
  assign fb.out_misalign = has_data && mis_mem[rd_ptr];
  assign fb.count        = cnt;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed vector table, hand-written corner
// sequences and a randomized run, all scored against a queue-based reference model.
module tb_fetch_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk;
  logic rst;

  fetch_buffer_if #(.AW(AW)) fb_bus ();

  fetch_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .fb  (fb_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    logic        rst;
    logic        in_valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        flush;
    logic        out_ready;
    int          exp_count;
    logic        exp_in_ready;
    logic        exp_out_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_mis;
  } vec_t;

  ent_t model_q[$];
  vec_t vecs[$];
  int   compared;
  int   mismatched;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic iv, input logic [31:0] pc,
                               input logic [31:0] instr, input logic fl, input logic ordy);
    rst              = r;
    fb_bus.in_valid  = iv;
    fb_bus.in_pc     = pc;
    fb_bus.in_instr  = instr;
    fb_bus.flush     = fl;
    fb_bus.out_ready = ordy;
    #1;
  endtask

  // Expected outputs come from the queue model as it stands before the coming edge
  task automatic checkOutput(input string name);
    int          n;
    logic [31:0] hpc;
    logic [31:0] hin;
    n   = model_q.size();
    hpc = (n != 0) ? model_q[0].pc    : 32'h0;
    hin = (n != 0) ? model_q[0].instr : 32'h0;
    cmp({name, "_count"},     32'(fb_bus.count),        32'(n));
    cmp({name, "_in_ready"},  32'(fb_bus.in_ready),     32'(n != DEPTH));
    cmp({name, "_out_valid"}, 32'(fb_bus.out_valid),    32'((n != 0) && !fb_bus.flush));
    cmp({name, "_out_pc"},    fb_bus.out_pc,            hpc);
    cmp({name, "_out_instr"}, fb_bus.out_instr,         hin);
    cmp({name, "_misalign"},  32'(fb_bus.out_misalign), 32'((n != 0) && (hpc[1:0] != 2'b00)));
  endtask

  task automatic stepClock();
    bit   do_push;
    bit   do_pop;
    ent_t e;
    do_push = fb_bus.in_valid && (model_q.size() != DEPTH) && !fb_bus.flush;
    do_pop  = (model_q.size() != 0) && !fb_bus.flush && fb_bus.out_ready;
    e.pc    = fb_bus.in_pc;
    e.instr = fb_bus.in_instr;
    @(posedge clk);
    if (rst || fb_bus.flush) begin
      model_q.delete();
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic addVec(input logic r, input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                        input logic fl, input logic ordy, input int ec, input logic erdy,
                        input logic eov, input logic [31:0] epc, input logic [31:0] ein, input logic emis);
    vec_t v;
    v.rst = r; v.in_valid = iv; v.pc = pc; v.instr = instr; v.flush = fl; v.out_ready = ordy;
    v.exp_count = ec; v.exp_in_ready = erdy; v.exp_out_valid = eov;
    v.exp_pc = epc; v.exp_instr = ein; v.exp_mis = emis;
    vecs.push_back(v);
  endtask

  initial begin
    string nm;
    compared   = 0;
    mismatched = 0;

    // Reset/idle, fill to full, refused push while popping, then drain in order
    addVec(1, 0, 32'h00, 32'h000, 0, 0, 0, 1, 0, 32'h00, 32'h000, 0);
    addVec(0, 0, 32'h00, 32'h000, 0, 0, 0, 1, 0, 32'h00, 32'h000, 0);
    addVec(0, 1, 32'h00, 32'h013, 0, 0, 0, 1, 0, 32'h00, 32'h000, 0);
    addVec(0, 1, 32'h04, 32'h093, 0, 0, 1, 1, 1, 32'h00, 32'h013, 0);
    addVec(0, 1, 32'h08, 32'h113, 0, 0, 2, 1, 1, 32'h00, 32'h013, 0);
    addVec(0, 1, 32'h0C, 32'h193, 0, 0, 3, 1, 1, 32'h00, 32'h013, 0);
    addVec(0, 1, 32'h10, 32'h213, 0, 0, 4, 0, 1, 32'h00, 32'h013, 0);
    addVec(0, 1, 32'h10, 32'h213, 0, 1, 4, 0, 1, 32'h00, 32'h013, 0);
    addVec(0, 0, 32'h00, 32'h000, 0, 1, 3, 1, 1, 32'h04, 32'h093, 0);
    addVec(0, 0, 32'h00, 32'h000, 0, 1, 2, 1, 1, 32'h08, 32'h113, 0);
    addVec(0, 0, 32'h00, 32'h000, 0, 1, 1, 1, 1, 32'h0C, 32'h193, 0);
    addVec(0, 0, 32'h00, 32'h000, 0, 1, 0, 1, 0, 32'h00, 32'h000, 0);

    applyStimulus(1, 0, 32'h0, 32'h0, 0, 0);
    stepClock();

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].in_valid, vecs[i].pc, vecs[i].instr,
                    vecs[i].flush, vecs[i].out_ready);
      nm = $sformatf("tbl%0d", i);
      cmp({nm, "_count"},     32'(fb_bus.count),        32'(vecs[i].exp_count));
      cmp({nm, "_in_ready"},  32'(fb_bus.in_ready),     32'(vecs[i].exp_in_ready));
      cmp({nm, "_out_valid"}, 32'(fb_bus.out_valid),    32'(vecs[i].exp_out_valid));
      cmp({nm, "_out_pc"},    fb_bus.out_pc,            vecs[i].exp_pc);
      cmp({nm, "_out_instr"}, fb_bus.out_instr,         vecs[i].exp_instr);
      cmp({nm, "_misalign"},  32'(fb_bus.out_misalign), 32'(vecs[i].exp_mis));
      checkOutput({nm, "_model"});
      stepClock();
    end

    // Steady push+pop at count 2 across several pointer wraps
    applyStimulus(0, 1, 32'h100, 32'hA100, 0, 0); checkOutput("wrap_fill0"); stepClock();
    applyStimulus(0, 1, 32'h104, 32'hA104, 0, 0); checkOutput("wrap_fill1"); stepClock();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 32'h108 + 32'(4*i), 32'hA108 + 32'(4*i), 0, 1);
      nm = $sformatf("wrap%0d", i);
      checkOutput(nm);
      cmp({nm, "_head"},  fb_bus.out_pc,      32'h100 + 32'(4*i));
      cmp({nm, "_count"}, 32'(fb_bus.count),  32'd2);
      stepClock();
    end

    // Grow to 3, then flush while a push is offered
    applyStimulus(0, 1, 32'h180, 32'hB180, 0, 0); checkOutput("pre_flush"); stepClock();
    applyStimulus(0, 1, 32'h200, 32'hC200, 1, 1);
    checkOutput("flush");
    cmp("flush_count3",    32'(fb_bus.count),     32'd3);
    cmp("flush_out_valid", 32'(fb_bus.out_valid), 32'd0);
    stepClock();
    applyStimulus(0, 1, 32'h300, 32'hC300, 0, 0);
    checkOutput("post_flush");
    cmp("post_flush_count", 32'(fb_bus.count), 32'd0);
    stepClock();
    applyStimulus(0, 1, 32'h102, 32'hD102, 0, 1);
    checkOutput("head300");
    cmp("head300_pc", fb_bus.out_pc, 32'h300);
    stepClock();

    // Misaligned entry reaches the head, then reset discards everything
    applyStimulus(0, 1, 32'h106, 32'hD106, 0, 0);
    checkOutput("mis_head");
    cmp("mis_head_flag", 32'(fb_bus.out_misalign), 32'd1);
    cmp("mis_head_pc",   fb_bus.out_pc,            32'h102);
    stepClock();
    applyStimulus(1, 1, 32'h10A, 32'hD10A, 0, 1);
    checkOutput("mid_reset");
    cmp("mid_reset_count2", 32'(fb_bus.count), 32'd2);
    stepClock();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 1);
    checkOutput("after_reset");
    cmp("after_reset_count", 32'(fb_bus.count),        32'd0);
    cmp("after_reset_mis",   32'(fb_bus.out_misalign), 32'd0);
    stepClock();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 1);
    checkOutput("no_stale");
    stepClock();

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rpc;
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      applyStimulus($urandom_range(0, 79) == 0, 1'($urandom_range(0, 2) != 0), rpc, $urandom,
                    $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)));
      checkOutput($sformatf("rnd%0d", i));
      stepClock();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Small instruction fetch queue. Sits directly downstream of the PC register and instruction memory, and upstream of decode.
- Captures {pc, instruction, misalign flag} triples from the fetch side with a valid/ready handshake.
- Presents them in order to decode with a second valid/ready handshake.
- Decouples fetch from decode back-pressure. A redirect (branch or jump) squashes all queued entries through flush.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- AW, 2, pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  fetch side offers an entry this cycle
- in_ready  output  1  buffer can accept an entry this cycle
- in_pc  input  32  PC of the fetched instruction
- in_instr  input  32  fetched instruction word
- flush  input  1  squash all entries (pipeline redirect)
- out_valid  output  1  head entry available to decode
- out_ready  input  1  decode accepts the head entry
- out_pc  output  32  PC of head entry
- out_instr  output  32  instruction of head entry
- out_misalign  output  1  head entry's PC had in_pc[1:0] != 0
- count  output  AW+1  number of entries currently held, 0..DEPTH

Behaviour:
- Reset: clk and rst are the only clock and reset. Reset is synchronous, active-high. When rst=1 at a rising edge:
  - write pointer, read pointer and count go to 0;
  - out_valid=0, out_pc=0, out_instr=0, out_misalign=0;
  - in_ready=1 after the edge.
- Reset mid-operation discards all entries with no partial drain. rst overrides flush, push and pop.
- Push: occurs when in_valid && in_ready && !flush.
  - Stores {in_pc, in_instr, in_pc[1:0]!=0} at the write pointer.
  - Write pointer increments, wrapping modulo DEPTH.
- Pop: occurs when out_valid && out_ready.
  - Read pointer increments, wrapping modulo DEPTH.
- Handshake outputs:
  - in_ready = (count != DEPTH). It is combinational from state only and does not depend on out_ready in the same cycle. A full buffer refuses a push even when a pop occurs in that cycle.
  - out_valid = (count != 0) && !flush.
- Count update:
  - push and pop in the same cycle: count unchanged;
  - push only: count+1;
  - pop only: count-1.
- Latency: an entry pushed at edge N is visible on out_* from edge N onward, i.e. one cycle after it was offered. There is no same-cycle bypass from in_* to out_*.
- Output data: out_pc, out_instr and out_misalign are read combinationally from the head entry while count != 0. They are forced to 0 while count == 0.
- Order: strict FIFO. Pointer wrap-around must not reorder or duplicate entries.
- flush=1 at an edge:
  - both pointers and count go to 0;
  - any push offered in that cycle is dropped;
  - no pop occurs, because out_valid is low.
- Flush timing: flush has priority over push and pop. The buffer is empty in the cycle after flush. A push in that following cycle is accepted normally.
- No overflow or underflow is possible: pushes are gated by in_ready and pops by out_valid.
- Misalignment is only flagged, never dropped. The trap decision belongs to a later stage.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then in_valid=0 -> count=0, in_ready=1, out_valid=0, out_pc=0, out_instr=0.
- Fill with out_ready=0: push pc=0x00, 0x04, 0x08, 0x0C (instr=0x13, 0x93, 0x113, 0x193) -> count=4, in_ready=0. A fifth push with pc=0x10 is refused, and out_pc stays 0x00.
- Drain in order: then out_ready=1 for 4 cycles -> out_pc sequence 0x00, 0x04, 0x08, 0x0C with matching instr. Afterwards count=0 and out_valid=0.
- Simultaneous push/pop with wrap: hold count=2 and push+pop every cycle for 10 cycles with pc incrementing by 4 from 0x100 -> count stays 2, and out_pc is always the pc pushed two cycles earlier across pointer wrap.
- Flush with concurrent push: count=3 and flush=1 with in_valid=1, in_pc=0x200 -> out_valid=0 that cycle; next cycle count=0 and 0x200 is absent. A push of 0x300 the following cycle appears at the head.
- Misalign and reset mid-stream: push pc=0x102 -> out_misalign=1 at the head. Then rst=1 with count=2 -> next cycle count=0, out_misalign=0, and no stale entries appear after reset.
